sample_arb: RTL



---
 rtl/sample_arb_pkg.sv | 35 +++
 rtl/sample_arb_if.sv | 28 ++
 rtl/sample_arb_rr.sv | 30 +++
 rtl/sample_arb.sv | 104 ++++++++++
 4 files changed

// File: rtl/sample_arb_pkg.sv
// sample_arb_pkg: shared definitions for the sample_arb slice.
//   - one-hot FSM state encoding
//   - default operand width and add constant
//   - add_const(): one pass of the add-constant datapath
// Configuration macro: SAMPLE_ARB_SAT_EN (saturate each pass instead of wrapping).
package sample_arb_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam logic [7:0]  DEF_CONSTVAL = 8'b1100_1001;

  // Widest datapath add_const() supports.
  localparam int unsigned MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b100,
    ST_CALC = 3'b010,
    ST_OUT  = 3'b001
  } state_e;

  // One pass of x + c limited to the low w bits; w must be in 1..MAX_W.
  function automatic logic [MAX_W-1:0] add_const(input logic [MAX_W-1:0] x,
                                                 input logic [MAX_W-1:0] c,
                                                 input int unsigned      w);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, x} + {1'b0, c};
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
`ifdef SAMPLE_ARB_SAT_EN
    if (sum > lim) sum = lim;
`endif
    sum = sum & lim;
    return sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sample_arb_if.sv
// sample_arb_if: requester, result and status signals of sample_arb.
//   slave  : the arbiter side (sample_arb)
//   master : the source/consumer side (upstream requesters and result sink)
interface sample_arb_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             res_ready;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/sample_arb_rr.sv
// sample_arb_rr: two-way round-robin grant.
//   i_valid0/i_valid1 : requests
//   i_last_grant      : requester granted most recently (0 or 1)
//   i_enable          : grants are forced low when deasserted
//   o_grant0/o_grant1 : one-hot (or zero) grant
module sample_arb_rr (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  input  logic i_enable,
  output logic o_grant0,
  output logic o_grant1
);

  always_comb begin
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    if (i_enable) begin
      if (i_valid0 && i_valid1) begin
        // contention: the requester that did not win last time goes first
        o_grant0 = i_last_grant;
        o_grant1 = ~i_last_grant;
      end else begin
        o_grant0 = i_valid0;
        o_grant1 = i_valid1;
      end
    end
  end

endmodule

// File: rtl/sample_arb.sv
// sample_arb: two-requester round-robin arbiter and sequencer for the shared
// add-constant datapath. One operand is accepted at a time, ITER passes of
// acc + CONSTVAL are run, and the result is returned tagged with the requester id.
//   clk, reset_n : clock (rising edge) and async active-low reset
//   bus (slave)  : req0/req1 valid/data/ready, res valid/data/id/ready, busy
// Parameters: WIDTH (1..16), CONSTVAL, ITER (1..15).
// Configuration macro: SAMPLE_ARB_SAT_EN (saturating passes, see sample_arb_pkg).
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | arbitrating, ready to accept an operand
// ST_CALC | running the ITER add passes
// ST_OUT  | result presented, waiting for res_ready
module sample_arb
  import sample_arb_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] CONSTVAL = WIDTH'(DEF_CONSTVAL),
  parameter int unsigned      ITER     = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  sample_arb_if.slave  bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [3:0]       r_cnt;
  logic             r_id;
  logic             r_last_grant;
  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_last_pass;
  logic [WIDTH-1:0] w_sum;

  // Ready is held low while reset is asserted, even though the state is ST_IDLE.
  assign w_idle      = (r_state == ST_IDLE) && reset_n;
  assign w_last_pass = (r_cnt == 4'(ITER - 1));
  assign w_sum       = WIDTH'(add_const(MAX_W'(r_acc), MAX_W'(CONSTVAL), WIDTH));

  sample_arb_rr u_rr (
    .i_valid0     (bus.req0_valid),
    .i_valid1     (bus.req1_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (w_idle),
    .o_grant0     (w_grant0),
    .o_grant1     (w_grant1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = (w_grant0 || w_grant1) ? ST_CALC : ST_IDLE;
      ST_CALC: w_state_nxt = w_last_pass ? ST_OUT : ST_CALC;
      ST_OUT:  w_state_nxt = bus.res_ready ? ST_IDLE : ST_OUT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant0) begin
            r_acc        <= bus.req0_data;
            r_id         <= 1'b0;
            r_last_grant <= 1'b0;
            r_cnt        <= '0;
          end else if (w_grant1) begin
            r_acc        <= bus.req1_data;
            r_id         <= 1'b1;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
          end
        end
        ST_CALC: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.res_valid  = (r_state == ST_OUT);
  assign bus.res_data   = (r_state == ST_OUT) ? r_acc : '0;
  assign bus.res_id     = (r_state == ST_OUT) ? r_id : 1'b0;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule
